md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It is the sequential companion to the datapath's combinational ALU and executes signed and unsigned multiply and divide plus the HI/LO write-through operations. Operand capture happens on a single-cycle start pulse. A busy flag stalls issue of further multiply/divide operations until the programmable latency has elapsed.

---
 rtl/md_unit_if.sv | 19 +
 rtl/md_unit.sv | 142 ++++++++++++++
 tb/tb_md_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: issue/result bundle of the multiply/divide unit.
//   A, B   operands (rs, rt)            MDOp  operation select
//   start  one-cycle issue qualifier    busy  operation in flight
//   HI, LO result registers
// master drives operands and issue; slave returns busy and HI/LO.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       MDOp;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output A, B, MDOp, start, input  busy, HI, LO);
    modport slave  (input  A, B, MDOp, start, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   md       md_unit_if slave: A/B/MDOp/start in, busy/HI/LO out
// mult/multu hold busy for MUL_CYCLES, div/divu for DIV_CYCLES, then commit
// on the cnt 1->0 edge. mthi/mtlo write through in one edge. Any start
// seen while busy is dropped.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset_n,
    md_unit_if.slave md
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    typedef struct packed {
        md_op_e           op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } md_req_t;

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    md_req_t          r_req, w_req_nxt;
    logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;

    // Multiply: both operands widened to 2*WIDTH so the full product fits.
    logic [2*WIDTH-1:0] w_prod_s, w_prod_u;
    assign w_prod_s = $signed({{WIDTH{r_req.a[WIDTH-1]}}, r_req.a}) *
                      $signed({{WIDTH{r_req.b[WIDTH-1]}}, r_req.b});
    assign w_prod_u = {{WIDTH{1'b0}}, r_req.a} * {{WIDTH{1'b0}}, r_req.b};

    // Divide: one unsigned divider on magnitudes, signs fixed up after.
    // The most-negative dividend has magnitude 2^(WIDTH-1) as an unsigned
    // value, so MIN / -1 naturally yields quotient MIN, remainder 0.
    logic             w_sgn, w_a_neg, w_b_neg, w_b_zero;
    logic [WIDTH-1:0] w_dvd, w_dvs, w_dvs_safe, w_qm, w_rm, w_quo, w_rem;
    assign w_sgn      = (r_req.op == OP_DIV);
    assign w_a_neg    = w_sgn & r_req.a[WIDTH-1];
    assign w_b_neg    = w_sgn & r_req.b[WIDTH-1];
    assign w_b_zero   = (r_req.b == '0);
    assign w_dvd      = w_a_neg ? -r_req.a : r_req.a;
    assign w_dvs      = w_b_neg ? -r_req.b : r_req.b;
    // Keep the divider defined on /0; that result is overridden at commit.
    assign w_dvs_safe = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_dvs;
    assign w_qm       = w_dvd / w_dvs_safe;
    assign w_rm       = w_dvd % w_dvs_safe;
    assign w_quo      = (w_a_neg ^ w_b_neg) ? -w_qm : w_qm;
    assign w_rem      = w_a_neg ? -w_rm : w_rm;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (md.start) begin
                    case (md_op_e'(md.MDOp))
                        OP_MULT, OP_MULTU: begin
                            w_req_nxt.op = md_op_e'(md.MDOp);
                            w_req_nxt.a  = md.A;
                            w_req_nxt.b  = md.B;
                            w_cnt_nxt    = CW'(MUL_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_req_nxt.op = md_op_e'(md.MDOp);
                            w_req_nxt.a  = md.A;
                            w_req_nxt.b  = md.B;
                            w_cnt_nxt    = CW'(DIV_CYCLES);
                            w_state_nxt  = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = md.A;
                        OP_MTLO: w_lo_nxt = md.A;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    case (r_req.op)
                        OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                        OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (w_b_zero) begin
                                w_lo_nxt = '1;
                                w_hi_nxt = r_req.a;
                            end else begin
                                w_lo_nxt = w_quo;
                                w_hi_nxt = w_rem;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // RUN tracks cnt != 0 exactly, so busy comes straight off the state flop.
    assign md.busy = (r_state == S_RUN);
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus();

    md_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .md(bus)
    );

    int vecs = 0;
    int errs = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        bit          noise;
    } vec_t;

    // Architectural reference: plain integer arithmetic on the operands.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint p;
        longint unsigned pu;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin pu = 64'(a) * 64'(b); hi = pu[63:32]; lo = pu[31:0]; end
            3'd3: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            3'd4: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    // Drive one start pulse; called at posedge+1, returns at posedge+1 of T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDOp = op; bus.A = a; bus.B = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Count consecutive busy cycles from now; optionally churn A/B/start.
    task automatic count_busy(output int n, input bit noise);
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            if (noise) begin
                bus.A = $urandom; bus.B = $urandom;
                bus.MDOp = 3'($urandom_range(0, 7));
                bus.start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            n++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.MDOp = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({bus.busy, bus.HI, bus.LO} !== 65'b0) begin
            errs++;
            $display("FAIL reset_hold busy=%b HI=%h LO=%h required 0/0/0", bus.busy, bus.HI, bus.LO);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if ({bus.busy, bus.HI, bus.LO} !== 65'b0) begin
            errs++;
            $display("FAIL reset_release busy=%b HI=%h LO=%h required 0/0/0", bus.busy, bus.HI, bus.LO);
        end
        m_hi = 0; m_lo = 0;
    endtask

    // Directed vectors issued back to back in the first idle cycle each time.
    task automatic test_directed;
        vec_t t[9];
        int n;
        t[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        t[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 1'b1};
        t[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        t[3] = '{3'd4, 32'd7,         32'd2,         32'd1,         32'd3,         1'b1};
        t[4] = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0};
        t[5] = '{3'd4, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0};
        t[6] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        t[7] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b1};
        t[8] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        for (int i = 0; i < 9; i++) begin
            issue(t[i].op, t[i].a, t[i].b);
            count_busy(n, t[i].noise);
            vecs++;
            if (n !== lat(t[i].op)) begin
                errs++;
                $display("FAIL dir%0d_busy_len got %0d required %0d", i, n, lat(t[i].op));
            end
            vecs++;
            if (bus.HI !== t[i].hi || bus.LO !== t[i].lo) begin
                errs++;
                $display("FAIL dir%0d_result HI=%h LO=%h required HI=%h LO=%h",
                         i, bus.HI, bus.LO, t[i].hi, t[i].lo);
            end
            m_hi = t[i].hi; m_lo = t[i].lo;
        end
    endtask

    task automatic test_interlock;
        int n;
        issue(3'd3, 32'd100, 32'd7);
        bus.MDOp = 3'd1; bus.A = 32'd3; bus.B = 32'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.MDOp = 3'd5; bus.A = 32'h1234; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        count_busy(n, 1'b0);
        vecs++;
        if (n + 2 !== DC) begin
            errs++;
            $display("FAIL lock_busy_len got %0d required %0d", n + 2, DC);
        end
        vecs++;
        if (bus.HI !== 32'd2 || bus.LO !== 32'd14) begin
            errs++;
            $display("FAIL lock_div_result HI=%h LO=%h required HI=2 LO=e", bus.HI, bus.LO);
        end
        issue(3'd5, 32'h1234, 32'd0);
        vecs++;
        if (bus.HI !== 32'h1234 || bus.LO !== 32'd14 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL lock_mthi HI=%h LO=%h busy=%b required 1234/e/0", bus.HI, bus.LO, bus.busy);
        end
        m_hi = 32'h1234; m_lo = 32'd14;
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        int n, r;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) b = 0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 17));
            else if (r == 3) b = -32'($urandom_range(1, 17));
            issue(op, a, b);
            model(op, a, b, m_hi, m_lo);
            count_busy(n, 1'($urandom_range(0, 1)));
            vecs++;
            if (n !== lat(op)) begin
                errs++;
                $display("FAIL rnd%0d_busy_len op=%0d got %0d required %0d", i, op, n, lat(op));
            end
            vecs++;
            if (bus.HI !== m_hi || bus.LO !== m_lo) begin
                errs++;
                $display("FAIL rnd%0d_result op=%0d A=%h B=%h HI=%h LO=%h required HI=%h LO=%h",
                         i, op, a, b, bus.HI, bus.LO, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_reset_midop;
        int bad;
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        issue(3'd6, 32'hCAFE_F00D, 32'd0);
        issue(3'd1, 32'h0000_1234, 32'h0000_5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        vecs++;
        if ({bus.busy, bus.HI, bus.LO} !== 65'b0) begin
            errs++;
            $display("FAIL midreset_async busy=%b HI=%h LO=%h required 0/0/0", bus.busy, bus.HI, bus.LO);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if ({bus.busy, bus.HI, bus.LO} !== 65'b0) bad++;
            @(posedge clk); #1;
        end
        vecs++;
        if (bad !== 0) begin
            errs++;
            $display("FAIL midreset_late_commit nonzero_cycles=%0d required 0", bad);
        end
        issue(3'd6, 32'h0000_00A5, 32'd0);
        vecs++;
        if (bus.LO !== 32'hA5 || bus.HI !== 32'd0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_mtlo LO=%h HI=%h busy=%b required a5/0/0", bus.LO, bus.HI, bus.busy);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_interlock;
        test_random;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
